// File: rtl/lcd_capture_if.sv
// lcd_capture_if
// Frame buffer write bus between the LCD capture block and the
// double-banked frame buffer RAM.
//   fb_we    one-cycle write strobe
//   fb_addr  byte address inside the bank being written
//   fb_data  four packed 2-bit pixels, leftmost pixel in [1:0]
//   fb_bank  bank currently being written; the scanner reads the other one
// master: the capture block (drives the bus)
// slave : the frame buffer RAM / scanner side (observes the bus)
interface lcd_capture_if #(
    parameter int ADDR_W = 13
);
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              fb_bank;

    modport master (
        output fb_we,
        output fb_addr,
        output fb_data,
        output fb_bank
    );

    modport slave (
        input fb_we,
        input fb_addr,
        input fb_data,
        input fb_bank
    );
endinterface

// File: rtl/lcd_capture.sv
// lcd_capture
// Rebuilds the gameboy LCD pixel stream into a packed, double-banked frame
// buffer (four 2-bit pixels per byte, H_PIXELS x V_LINES per bank).
// Ports:
//   clock, reset          core clock, synchronous active-high reset
//   enable                capture enable (sampled alongside the strobes)
//   pixel_data[1:0]       shade of the pixel carried by a pixel_clock rise
//   pixel_clock           rising edge = one pixel
//   pixel_latch           rising edge = end of line
//   vsync                 rising edge = frame boundary
//   fb                    frame buffer write bus (lcd_capture_if.master)
//   frame_done            pulse per complete frame
//   line_err              pulse per malformed line (short line / overrun)
//   frame_err             pulse per malformed frame
//   frame_count[7:0]      complete frames seen, wrapping
module lcd_capture #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 13
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           pixel_data,
    input  logic                 pixel_clock,
    input  logic                 pixel_latch,
    input  logic                 vsync,
    lcd_capture_if.master        fb,
    output logic                 frame_done,
    output logic                 line_err,
    output logic                 frame_err,
    output logic [7:0]           frame_count
);

    localparam int XW = $clog2(H_PIXELS + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam logic [XW-1:0]     X_END      = XW'(H_PIXELS);
    localparam logic [YW-1:0]     Y_END      = YW'(V_LINES);
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(H_PIXELS / 4);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state, n_state;

    // Input sample registers and their previous values for edge detection.
    // pixel_data and enable are sampled with the strobes so that one sample
    // decides everything about a given edge.
    logic              pclk_q, pclk_prev;
    logic              latch_q, latch_prev;
    logic              vsync_q, vsync_prev;
    logic              enable_q;
    logic [1:0]        pd_q;

    logic [XW-1:0]     x, nx;
    logic [YW-1:0]     y, ny;
    logic [5:0]        pack, npack;
    logic              overrun_seen, n_ovr;

    logic              we_r, n_we;
    logic [ADDR_W-1:0] addr_r, n_addr;
    logic [7:0]        data_r, n_data;
    logic              bank_r, n_bank;
    logic              n_lerr, n_ferr, n_done;
    logic [7:0]        n_count;

    logic              pixel_rise, latch_rise, vsync_rise;

    assign pixel_rise = pclk_q  & ~pclk_prev;
    assign latch_rise = latch_q & ~latch_prev;
    assign vsync_rise = vsync_q & ~vsync_prev;

    assign fb.fb_we   = we_r;
    assign fb.fb_addr = addr_r;
    assign fb.fb_data = data_r;
    assign fb.fb_bank = bank_r;

    // Next-state computation. Edges detected in the same cycle are applied in
    // the order pixel, line end, frame end, each step seeing the x/y left by
    // the previous one.
    always_comb begin
        n_state = state;
        nx      = x;
        ny      = y;
        npack   = pack;
        n_ovr   = overrun_seen;
        n_we    = 1'b0;
        n_addr  = addr_r;
        n_data  = data_r;
        n_bank  = bank_r;
        n_count = frame_count;
        n_lerr  = 1'b0;
        n_ferr  = 1'b0;
        n_done  = 1'b0;

        if (!enable_q) begin
            n_state = IDLE;
            nx      = '0;
            ny      = '0;
            npack   = '0;
            n_ovr   = 1'b0;
        end else if (state == IDLE) begin
            if (vsync_rise) begin
                n_state = ACTIVE;
                nx      = '0;
                ny      = '0;
                npack   = '0;
                n_ovr   = 1'b0;
            end
        end else begin
            if (pixel_rise) begin
                if (ny == Y_END) begin
                    n_ferr = 1'b1;
                end else if (nx == X_END) begin
                    // Overrun: report only the first surplus pixel of the line.
                    n_lerr = ~overrun_seen;
                    n_ovr  = 1'b1;
                end else begin
                    case (nx[1:0])
                        2'd0: npack[1:0] = pd_q;
                        2'd1: npack[3:2] = pd_q;
                        2'd2: npack[5:4] = pd_q;
                        default: begin
                            n_we   = 1'b1;
                            n_data = {pd_q, npack};
                            n_addr = ADDR_W'(ny) * LINE_BYTES + ADDR_W'(nx >> 2);
                        end
                    endcase
                    nx = nx + XW'(1);
                end
            end

            if (latch_rise && nx != '0) begin
                // A short line loses its partial word; a latch on an empty
                // line does nothing at all.
                n_lerr = (nx != X_END);
                npack  = '0;
                nx     = '0;
                n_ovr  = 1'b0;
                if (ny != Y_END) begin
                    ny = ny + YW'(1);
                end
            end

            if (vsync_rise) begin
                if (ny == Y_END) begin
                    n_done  = 1'b1;
                    n_bank  = ~bank_r;
                    n_count = frame_count + 8'd1;
                end else begin
                    n_ferr = 1'b1;
                end
                nx    = '0;
                ny    = '0;
                npack = '0;
                n_ovr = 1'b0;
            end
        end
    end

    // All state and every output are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            pclk_q       <= 1'b0;
            pclk_prev    <= 1'b0;
            latch_q      <= 1'b0;
            latch_prev   <= 1'b0;
            vsync_q      <= 1'b0;
            vsync_prev   <= 1'b0;
            enable_q     <= 1'b0;
            pd_q         <= 2'd0;
            x            <= '0;
            y            <= '0;
            pack         <= '0;
            overrun_seen <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            data_r       <= 8'd0;
            bank_r       <= 1'b0;
            frame_done   <= 1'b0;
            line_err     <= 1'b0;
            frame_err    <= 1'b0;
            frame_count  <= 8'd0;
        end else begin
            pclk_q       <= pixel_clock;
            pclk_prev    <= pclk_q;
            latch_q      <= pixel_latch;
            latch_prev   <= latch_q;
            vsync_q      <= vsync;
            vsync_prev   <= vsync_q;
            enable_q     <= enable;
            pd_q         <= pixel_data;
            state        <= n_state;
            x            <= nx;
            y            <= ny;
            pack         <= npack;
            overrun_seen <= n_ovr;
            we_r         <= n_we;
            addr_r       <= n_addr;
            data_r       <= n_data;
            bank_r       <= n_bank;
            frame_done   <= n_done;
            line_err     <= n_lerr;
            frame_err    <= n_ferr;
            frame_count  <= n_count;
        end
    end

endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture
// Drives the LCD pixel stream into lcd_capture and compares every output,
// every cycle, against a pixel/line/frame counting model of the receiver.
module tb_lcd_capture;

    localparam int H  = 160;
    localparam int V  = 144;
    localparam int AW = 13;
    localparam int LB = H / 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pixel_data = 2'd0;
    logic       pixel_clock = 1'b0;
    logic       pixel_latch = 1'b0;
    logic       vsync = 1'b0;
    logic       frame_done, line_err, frame_err;
    logic [7:0] frame_count;

    lcd_capture_if #(.ADDR_W(AW)) fb_if ();

    lcd_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pixel_data  (pixel_data),
        .pixel_clock (pixel_clock),
        .pixel_latch (pixel_latch),
        .vsync       (vsync),
        .fb          (fb_if),
        .frame_done  (frame_done),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit checking     = 1'b0;

    typedef struct {
        bit we;
        bit chk_ad;
        int addr;
        int data;
        bit bank;
        bit done;
        bit lerr;
        bit ferr;
        int count;
    } rec_t;

    rec_t exp_d1, exp_d2;

    // Model state: position in the frame as counts, the pixels of the word
    // being assembled, and the frame-level bookkeeping.
    bit m_active;
    int m_px, m_ln;
    bit m_ovr;
    int m_word[$];
    bit m_bank;
    int m_count, m_addr, m_data;
    bit m_pc_prev, m_pl_prev, m_vs_prev;

    // DUT activity seen during the current test phase
    int obs_addr[$];
    int obs_data[$];
    int obs_lerr, obs_ferr, obs_done;

    task automatic check_output(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_px = 0;
        m_ln = 0;
        m_ovr = 1'b0;
        m_word.delete();
    endtask

    task automatic model_step(output rec_t r);
        bit pe, le, ve;
        pe = pixel_clock && !m_pc_prev;
        le = pixel_latch && !m_pl_prev;
        ve = vsync && !m_vs_prev;
        m_pc_prev = pixel_clock;
        m_pl_prev = pixel_latch;
        m_vs_prev = vsync;
        r = '{default: 0};
        if (!enable) begin
            m_active = 1'b0;
            model_clear();
        end else if (!m_active) begin
            if (ve) begin
                m_active = 1'b1;
                model_clear();
            end
        end else begin
            if (pe) begin
                if (m_ln == V) r.ferr = 1'b1;
                else if (m_px == H) begin
                    if (!m_ovr) r.lerr = 1'b1;
                    m_ovr = 1'b1;
                end else begin
                    m_word.push_back(int'(pixel_data));
                    m_px++;
                    if (m_word.size() == 4) begin
                        m_data = m_word[0] + 4 * m_word[1] + 16 * m_word[2] + 64 * m_word[3];
                        m_addr = m_ln * LB + (m_px - 1) / 4;
                        r.we = 1'b1;
                        m_word.delete();
                    end
                end
            end
            if (le && m_px > 0) begin
                if (m_px < H) r.lerr = 1'b1;
                m_px = 0;
                m_ovr = 1'b0;
                m_word.delete();
                if (m_ln < V) m_ln++;
            end
            if (ve) begin
                if (m_ln == V) begin
                    r.done = 1'b1;
                    m_bank = !m_bank;
                    m_count = (m_count + 1) % 256;
                end else begin
                    r.ferr = 1'b1;
                end
                model_clear();
            end
        end
        r.chk_ad = r.we;
        r.addr   = m_addr;
        r.data   = m_data;
        r.bank   = m_bank;
        r.count  = m_count;
    endtask

    // Outputs for an input sampled at the next posedge appear two negedges
    // later, so expectations travel through a two-stage pipe.
    always @(negedge clock) begin
        if (checking) begin
            check_output("fb_we", int'(fb_if.fb_we), int'(exp_d2.we));
            if (exp_d2.chk_ad) begin
                check_output("fb_addr", int'(fb_if.fb_addr), exp_d2.addr);
                check_output("fb_data", int'(fb_if.fb_data), exp_d2.data);
            end
            check_output("fb_bank", int'(fb_if.fb_bank), int'(exp_d2.bank));
            check_output("frame_done", int'(frame_done), int'(exp_d2.done));
            check_output("line_err", int'(line_err), int'(exp_d2.lerr));
            check_output("frame_err", int'(frame_err), int'(exp_d2.ferr));
            check_output("frame_count", int'(frame_count), exp_d2.count);
            if (fb_if.fb_we) begin
                obs_addr.push_back(int'(fb_if.fb_addr));
                obs_data.push_back(int'(fb_if.fb_data));
            end
            if (line_err) obs_lerr++;
            if (frame_err) obs_ferr++;
            if (frame_done) obs_done++;
        end
        exp_d2 = exp_d1;
        if (reset) begin
            m_active = 1'b0;
            model_clear();
            m_bank = 1'b0;
            m_count = 0;
            m_addr = 0;
            m_data = 0;
            m_pc_prev = 1'b0;
            m_pl_prev = 1'b0;
            m_vs_prev = 1'b0;
            exp_d1 = '{default: 0};
            exp_d1.chk_ad = 1'b1;
            exp_d2 = exp_d1;
        end else begin
            model_step(exp_d1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_lerr = 0;
        obs_ferr = 0;
        obs_done = 0;
    endtask

    // One strobe cycle with the chosen edges, then a low cycle with the
    // data still held, then optional idle gap cycles.
    task automatic apply_stimulus(input bit pc, input bit pl, input bit vs,
                                  input logic [1:0] pd, input int gap);
        pixel_clock = pc;
        pixel_latch = pl;
        vsync = vs;
        if (pc) pixel_data = pd;
        tick();
        pixel_clock = 1'b0;
        pixel_latch = 1'b0;
        vsync = 1'b0;
        tick();
        repeat (gap) tick();
    endtask

    task automatic send_pixels(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) apply_stimulus(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            else     apply_stimulus(1'b1, 1'b0, 1'b0, 2'(i % 4), 0);
        end
    endtask

    task automatic send_latch();
        apply_stimulus(1'b0, 1'b1, 1'b0, 2'd0, 0);
    endtask

    task automatic send_vsync();
        apply_stimulus(1'b0, 1'b0, 1'b1, 2'd0, 0);
    endtask

    // A line of n pixels; with merge the last pixel and the latch rise together.
    task automatic send_line(input int n, input bit merge, input bit rnd);
        if (merge && n > 0) begin
            send_pixels(n - 1, rnd);
            apply_stimulus(1'b1, 1'b1, 1'b0, rnd ? 2'($urandom_range(0, 3)) : 2'((n - 1) % 4), 0);
        end else begin
            send_pixels(n, rnd);
            send_latch();
        end
    endtask

    initial begin
        int bad;
        int cnt;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        tick();
        checking = 1'b1;
        check_output("rst_fb_we", int'(fb_if.fb_we), 0);
        check_output("rst_fb_bank", int'(fb_if.fb_bank), 0);
        check_output("rst_frame_count", int'(frame_count), 0);
        enable = 1'b1;
        tick();

        // Frame 1: complete frame, line 5 short by two pixels, line 9 ends
        // with pixel and latch rising together.
        send_vsync();
        clear_obs();
        for (int ln = 0; ln < V; ln++) send_line((ln == 5) ? 158 : 160, ln == 9, 1'b0);
        send_vsync();
        settle();
        check_output("f1_writes", obs_addr.size(), 5759);
        bad = 0;
        for (int i = 0; i < obs_data.size(); i++) if (obs_data[i] != 8'hE4) bad++;
        check_output("f1_bad_data", bad, 0);
        bad = 0;
        for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] != ((i < 239) ? i : i + 1)) bad++;
        check_output("f1_bad_order", bad, 0);
        check_output("f1_line6_start", obs_addr[239], 240);
        check_output("f1_line_err", obs_lerr, 1);
        check_output("f1_frame_err", obs_ferr, 0);
        check_output("f1_frame_done", obs_done, 1);
        check_output("f1_bank", int'(fb_if.fb_bank), 1);
        check_output("f1_count", int'(frame_count), 1);

        // Overrun on line 0 and a frame of only 12 lines.
        clear_obs();
        send_line(162, 1'b0, 1'b0);
        for (int ln = 1; ln < 12; ln++) send_line(160, 1'b0, 1'b0);
        send_vsync();
        settle();
        check_output("ov_writes", obs_addr.size(), 480);
        cnt = 0;
        for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] < LB) cnt++;
        check_output("ov_line0_writes", cnt, 40);
        check_output("ov_line_err", obs_lerr, 1);
        check_output("ov_frame_err", obs_ferr, 1);
        check_output("ov_frame_done", obs_done, 0);
        check_output("ov_bank", int'(fb_if.fb_bank), 1);
        check_output("ov_count", int'(frame_count), 1);

        // enable dropped in the middle of line 10
        clear_obs();
        for (int ln = 0; ln < 10; ln++) send_line(160, 1'b0, 1'b0);
        send_pixels(80, 1'b0);
        settle();
        check_output("en_writes_before", obs_addr.size(), 420);
        enable = 1'b0;
        clear_obs();
        send_pixels(80, 1'b0);
        send_latch();
        send_line(160, 1'b0, 1'b0);
        settle();
        check_output("en_writes_off", obs_addr.size(), 0);
        check_output("en_bank_held", int'(fb_if.fb_bank), 1);
        enable = 1'b1;
        tick();
        send_line(20, 1'b0, 1'b0);
        settle();
        check_output("en_writes_idle", obs_addr.size(), 0);
        send_vsync();
        clear_obs();
        send_line(8, 1'b0, 1'b0);
        settle();
        check_output("en_resume_writes", obs_addr.size(), 2);
        check_output("en_resume_addr", obs_addr[0], 0);

        // Reset mid-frame while a write is in flight
        send_pixels(7, 1'b0);
        pixel_clock = 1'b1;
        pixel_data = 2'd2;
        tick();
        pixel_clock = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_output("mr_fb_we", int'(fb_if.fb_we), 0);
        check_output("mr_fb_addr", int'(fb_if.fb_addr), 0);
        check_output("mr_fb_data", int'(fb_if.fb_data), 0);
        check_output("mr_fb_bank", int'(fb_if.fb_bank), 0);
        check_output("mr_frame_count", int'(frame_count), 0);
        check_output("mr_line_err", int'(line_err), 0);
        #1;
        reset = 1'b0;
        tick();
        clear_obs();
        send_line(8, 1'b0, 1'b0);
        settle();
        check_output("mr_writes_no_vsync", obs_addr.size(), 0);
        send_vsync();
        clear_obs();
        send_line(8, 1'b0, 1'b0);
        settle();
        check_output("mr_resume_addr", obs_addr[0], 0);

        // Randomized lines, gaps, data, enable drops and frame boundaries
        for (int it = 0; it < 24; it++) begin
            int sel;
            int len;
            sel = int'($urandom_range(0, 9));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 163)) : 160;
            if (sel == 0) begin
                send_vsync();
            end else if (sel == 1) begin
                send_pixels(len, 1'b1);
                apply_stimulus(1'b0, 1'b1, 1'b1, 2'd0, 0);
            end else if (sel == 2) begin
                enable = 1'b0;
                send_pixels(int'($urandom_range(1, 8)), 1'b1);
                enable = 1'b1;
                tick();
            end else begin
                send_line(len, 1'($urandom_range(0, 1)), 1'b1);
            end
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
